dtm_dmi_request: RTL
====================

# dtm_dmi_request

Debug Transport Module request sequencer: sits directly upstream of the debug module's DMI and drives the `jtag` side of `dmi_interface`. It turns single-cycle DMI-register update strobes from the TAP controller into a DMI request handshake, and holds the returned read data and status for the next capture. It also implements the RISC-V `dmistat` sticky-error rules (busy, failed), plus the `dmireset` and `dmihardreset` controls. All TAP strobes arrive already synchronised into the core clock domain.

## Interface
- `TIMEOUT_CYCLES`, default 1024: cycles `new_request` may stay high without `handled`. Used only with `DMI_TIMEOUT_EN`.
- `clk` input 1: core clock.
- `rst` input 1: synchronous, active-high reset.
- `dmi_update` input 1: single-cycle strobe; TAP Update-DR of the DMI register.
- `dmi_update_value` input 41: `{address[40:34], data[33:2], op[1:0]}`; valid with `dmi_update`.
- `dmireset` input 1: single-cycle strobe; clears the sticky error.
- `dmihardreset` input 1: single-cycle strobe; aborts any request and clears all state.
- `dmi_capture_value` output 41: `{last_address, last_read_data, status}`; TAP shifts it out.
- `dmistat` output 2: current status for the DTMCS register.
- `dmi` modport `dmi_interface.jtag`: outputs `address`, `jtag_data`, `new_request`, `rnw`; inputs `handled`, `response`, `dmi_data`.

## Operation
- Op encoding: 0 nop, 1 read, 2 write, 3 reserved (treated as nop).
- Status encoding: 0 success, 2 failed, 3 busy.
- States:
  - IDLE: waiting for an update.
  - REQ: `new_request` high, waiting for `handled`.
- IDLE -> REQ when all hold: `dmi_update`, op is 1 or 2, and sticky == 0.
  - On entry, latch `address`, `jtag_data` and `rnw` (op==1); `rnw` is 1 for a read.
  - Latched values stay stable for the whole REQ state.
- REQ -> IDLE on `handled`.
  - `response != 0`: sticky <= 2 (only if sticky == 0).
  - `response == 0` and the request was a read: `last_read_data <= dmi_data`.
  - A write leaves `last_read_data` unchanged.
- `dmi_update` with op 1/2 while in REQ: request dropped; sticky <= 3 if sticky == 0.
- `dmi_update` with op 1/2 while sticky != 0: request ignored; no state change.
- `dmi_update` with op 0/3: no request is issued; `last_address` is unchanged.
- `last_address` updates on every accepted request.
- `dmistat`:
  - sticky if sticky != 0;
  - else 3 while in REQ;
  - else 0.
- Status field of `dmi_capture_value` equals `dmistat`.
- `dmireset`: sticky <= 0. It does not abort an outstanding request.
- `dmihardreset`: same effect as `rst` on everything except the pipeline timing; `new_request` drops the next cycle. A `handled` arriving later is ignored.
- Reset values:
  - state IDLE;
  - `new_request`, `rnw` 0;
  - `address`, `jtag_data` 0;
  - sticky 0;
  - `last_address`, `last_read_data` 0;
  - `dmistat` 0.

## Timing
- `dmi_update` accepted in cycle N -> `new_request` high from cycle N+1. All outputs are registered.
- `handled` sampled high in cycle M -> `new_request` low and `dmistat` updated in M+1.
  - `handled` may arrive in the first cycle `new_request` is high.
  - Minimum request occupancy is 1 cycle.
- Back-to-back: an update in cycle M+1 is accepted.
- An update in the same cycle as `handled` counts as busy: sticky <= 3.
- Priority within one cycle: `rst` > `dmihardreset` > `handled` > `dmireset` > `dmi_update`.
  - `dmireset` together with `dmi_update` in IDLE: the sticky error is cleared and the update is accepted.
- `handled` while in IDLE: ignored.

## Configuration
- `DMI_TIMEOUT_EN` defined:
  - Counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on REQ entry and increments each REQ cycle.
  - On reaching `TIMEOUT_CYCLES` without `handled`: return to IDLE, drop `new_request`, sticky <= 2.
  - `handled` in the terminal cycle wins over the timeout.
- `DMI_TIMEOUT_EN` undefined: no counter; REQ waits indefinitely for `handled`.

## Structure
- Shared package `dtm_pkg` holds:
  - `dmi_op_t` and `dmi_status_t` enums;
  - `dmi_req_t` packed struct (41 bits);
  - `DMI_ADDR_W = 7` and `DMI_DATA_W = 32`.
- One sub-module, `dtm_timeout_counter`, instantiated only under `DMI_TIMEOUT_EN`. Ports: `clk`, `rst`, `clear`, `enable`, `expired`.

## Test plan
- Read: update `{0x11, x, 1}` -> `new_request` high next cycle with `address=0x11`, `rnw=1`. Drive `handled` with `dmi_data=0xDEADBEEF`, `response=0` -> capture `{0x11, 0xDEADBEEF, 0}`.
- Write: update `{0x04, 0x12345678, 2}` -> `jtag_data=0x12345678`, `rnw=0`. After `handled`, `last_read_data` is unchanged and `dmistat=0`.
- Busy: second update while in REQ -> `dmistat=3` that persists after `handled`. A further update issues no request. `dmireset` -> `dmistat=0`; next update accepted.
- Failed: `handled` with `response=2` -> `dmistat=2`. Subsequent reads ignored until `dmireset`.
- Hard reset: `dmihardreset` during REQ -> `new_request` low next cycle. A late `handled` is ignored; capture value all zero.
- With `DMI_TIMEOUT_EN`, `TIMEOUT_CYCLES=8`: withhold `handled` -> `new_request` drops after 8 REQ cycles and `dmistat=2`.

Source files
------------

// File: rtl/dtm_pkg.sv
// dtm_pkg: shared DMI types and widths for the debug transport module
package dtm_pkg;
    localparam int DMI_ADDR_W = 7;
    localparam int DMI_DATA_W = 32;

    typedef enum logic [1:0] {
        DMI_OP_NOP   = 2'd0,
        DMI_OP_READ  = 2'd1,
        DMI_OP_WRITE = 2'd2,
        DMI_OP_RSVD  = 2'd3
    } dmi_op_t;

    typedef enum logic [1:0] {
        DMI_STATUS_SUCCESS = 2'd0,
        DMI_STATUS_FAILED  = 2'd2,
        DMI_STATUS_BUSY    = 2'd3
    } dmi_status_t;

    typedef struct packed {
        logic [DMI_ADDR_W-1:0] address;
        logic [DMI_DATA_W-1:0] data;
        dmi_op_t               op;
    } dmi_req_t;
endpackage

// File: rtl/dmi_interface.sv
// dmi_interface: request/response link between the DTM (jtag side) and the debug module (dm side)
interface dmi_interface;
    import dtm_pkg::*;
    logic [DMI_ADDR_W-1:0] address;
    logic [DMI_DATA_W-1:0] jtag_data;
    logic                  new_request;
    logic                  rnw;
    logic                  handled;
    logic [1:0]            response;
    logic [DMI_DATA_W-1:0] dmi_data;

    modport jtag (
        output address, jtag_data, new_request, rnw,
        input  handled, response, dmi_data
    );

    modport dm (
        input  address, jtag_data, new_request, rnw,
        output handled, response, dmi_data
    );
endinterface

// File: rtl/dtm_timeout_counter.sv
// dtm_timeout_counter: counts cycles of an outstanding request and flags the last cycle allowed
module dtm_timeout_counter #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // Count waiting cycles; a newly accepted request restarts from zero
    always_ff @(posedge clk) begin
        if (rst || clear) count <= '0;
        else if (enable && !expired) count <= count + 1'b1;
    end

    assign expired = enable && count == CW'(LIMIT - 1);
endmodule

// File: rtl/dtm_dmi_request.sv
// dtm_dmi_request: turns TAP DMI updates into DMI requests with sticky busy/failed status; DMI_TIMEOUT_EN adds a request timeout
module dtm_dmi_request
    import dtm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmi_update,
    input  logic [40:0] dmi_update_value,
    input  logic        dmireset,
    input  logic        dmihardreset,
    output logic [40:0] dmi_capture_value,
    output logic [1:0]  dmistat,
    dmi_interface.jtag  dmi
);
    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t                state, state_n;
    dmi_status_t           sticky, sticky_n, sticky_eff;
    dmi_req_t              req;
    logic [DMI_ADDR_W-1:0] address, last_address;
    logic [DMI_DATA_W-1:0] jtag_data, last_read_data;
    logic                  rnw, is_rw, accept, busy, done, fail, read_done, expired;

    assign req = dmi_req_t'(dmi_update_value);

`ifdef DMI_TIMEOUT_EN
    dtm_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst     (rst || dmihardreset),
        .clear   (accept),
        .enable  (state == REQ),
        .expired (expired)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign expired = 1'b0;
`endif

    // Next state and sticky status; handled/timeout outrank dmireset, which outranks a new update
    always_comb begin
        is_rw      = req.op == DMI_OP_READ || req.op == DMI_OP_WRITE;
        sticky_eff = dmireset ? DMI_STATUS_SUCCESS : sticky;
        done       = state == REQ && (dmi.handled || expired);
        fail       = state == REQ && (dmi.handled ? dmi.response != 2'd0 : expired);
        read_done  = state == REQ && dmi.handled && dmi.response == 2'd0 && rnw;
        accept     = state == IDLE && dmi_update && is_rw && sticky_eff == DMI_STATUS_SUCCESS;
        busy       = state == REQ && dmi_update && is_rw;
        state_n    = accept ? REQ : done ? IDLE : state;
        sticky_n   = sticky_eff != DMI_STATUS_SUCCESS ? sticky_eff :
                     fail ? DMI_STATUS_FAILED :
                     busy ? DMI_STATUS_BUSY : DMI_STATUS_SUCCESS;
    end

    // State, latched request and captured results; dmihardreset behaves like rst
    always_ff @(posedge clk) begin
        if (rst || dmihardreset) begin
            state          <= IDLE;
            sticky         <= DMI_STATUS_SUCCESS;
            address        <= '0;
            jtag_data      <= '0;
            rnw            <= 1'b0;
            last_address   <= '0;
            last_read_data <= '0;
        end else begin
            state  <= state_n;
            sticky <= sticky_n;
            if (accept) begin
                address      <= req.address;
                jtag_data    <= req.data;
                rnw          <= req.op == DMI_OP_READ;
                last_address <= req.address;
            end
            if (read_done) last_read_data <= dmi.dmi_data;
        end
    end

    assign dmi.new_request     = state == REQ;
    assign dmi.address         = address;
    assign dmi.jtag_data       = jtag_data;
    assign dmi.rnw             = rnw;
    assign dmistat             = sticky != DMI_STATUS_SUCCESS ? sticky :
                                 state == REQ ? DMI_STATUS_BUSY : DMI_STATUS_SUCCESS;
    assign dmi_capture_value   = {last_address, last_read_data, dmistat};
endmodule
